// File: rtl/id_pkg.sv
// op_code: opcode, ALU-op and decoded-control types plus instruction field positions shared by the decoder and bench
package op_code;
  typedef enum logic [3:0] {
    NOP, ADD_R, SUB_R, AND_R, OR_R, XOR_R, ADD_M, SUB_M,
    LD_AR, LD_AM, LD_AI, ST_RA, ST_MA, LD_RM, NOT_A, CLR_A
  } full_operation;
  typedef enum logic [2:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_CLR
  } alu_op_t;
  localparam int OPERAND_MSB = 15;
  localparam int OPERAND_LSB = 6;
  localparam int DIRECT_MSB  = 13;
  localparam int OP_MSB      = 5;
  localparam int OP_LSB      = 2;
  localparam int RF_MSB      = 1;
  localparam int RF_LSB      = 0;
  typedef struct packed {
    alu_op_t     op;
    logic [1:0]  rf_addr;
    logic [2:0]  rf_ce;
    logic [9:0]  mem_addr;
    logic        mem_wr;
    logic        mem_rd;
    logic        acc_ce;
    logic [7:0]  direct_data;
    logic        direct_load;
  } dec_t;
endpackage

// File: rtl/id.sv
// id: registered instruction decoder of the accumulator CPU, one cycle from instruction to controls
module id
  import op_code::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_instruction,
  output logic [2:0]  o_operation_code,
  output logic [1:0]  o_register_file_addr,
  output logic [2:0]  o_register_file_ce,
  output logic [9:0]  o_data_memory_addr,
  output logic        o_memory_write_enable,
  output logic        o_memory_read_enable,
  output logic        o_acumulator_ce,
  output logic [7:0]  o_direct_data,
  output logic        o_direct_load
);
  full_operation op;
  dec_t dec_d, dec_q;
  assign op = full_operation'(i_instruction[OP_MSB:OP_LSB]);
  always_comb begin
    dec_d = '0;
    dec_d.rf_addr = i_instruction[RF_MSB:RF_LSB];
    dec_d.mem_addr = i_instruction[OPERAND_MSB:OPERAND_LSB];
    dec_d.direct_data = i_instruction[DIRECT_MSB:OPERAND_LSB];
    case (op)
      NOP: ;
      ADD_R: begin dec_d.op = ALU_ADD; dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      SUB_R: begin dec_d.op = ALU_SUB; dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      AND_R: begin dec_d.op = ALU_AND; dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      OR_R:  begin dec_d.op = ALU_OR;  dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      XOR_R: begin dec_d.op = ALU_XOR; dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      ADD_M: begin dec_d.op = ALU_ADD; dec_d.mem_rd = 1'b1; dec_d.acc_ce = 1'b1; end
      SUB_M: begin dec_d.op = ALU_SUB; dec_d.mem_rd = 1'b1; dec_d.acc_ce = 1'b1; end
      LD_AR: begin dec_d.rf_ce[0] = 1'b1; dec_d.acc_ce = 1'b1; end
      LD_AM: begin dec_d.mem_rd = 1'b1; dec_d.acc_ce = 1'b1; end
      LD_AI: begin dec_d.direct_load = 1'b1; dec_d.acc_ce = 1'b1; end
      ST_RA: dec_d.rf_ce[1] = 1'b1;
      ST_MA: dec_d.mem_wr = 1'b1;
      LD_RM: begin dec_d.mem_rd = 1'b1; dec_d.rf_ce[2] = 1'b1; end
      NOT_A: begin dec_d.op = ALU_NOT; dec_d.acc_ce = 1'b1; end
      CLR_A: begin dec_d.op = ALU_CLR; dec_d.acc_ce = 1'b1; end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) dec_q <= '0;
    else dec_q <= dec_d;
  end
  assign o_operation_code = dec_q.op;
  assign o_register_file_addr = dec_q.rf_addr;
  assign o_register_file_ce = dec_q.rf_ce;
  assign o_data_memory_addr = dec_q.mem_addr;
  assign o_memory_write_enable = dec_q.mem_wr;
  assign o_memory_read_enable = dec_q.mem_rd;
  assign o_acumulator_ce = dec_q.acc_ce;
  assign o_direct_data = dec_q.direct_data;
  assign o_direct_load = dec_q.direct_load;
endmodule

// File: tb/tb_id.sv
// tb_id: directed and streamed checks of the instruction decoder against a rule-based model
module tb_id;
  import op_code::*;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_instruction = 16'hFFFF;
  logic [2:0]  o_operation_code;
  logic [1:0]  o_register_file_addr;
  logic [2:0]  o_register_file_ce;
  logic [9:0]  o_data_memory_addr;
  logic        o_memory_write_enable;
  logic        o_memory_read_enable;
  logic        o_acumulator_ce;
  logic [7:0]  o_direct_data;
  logic        o_direct_load;
  int total = 0;
  int bad = 0;
  logic [29:0] act, exp_q;
  logic exp_valid = 1'b0;

  id dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instruction(i_instruction),
    .o_operation_code(o_operation_code), .o_register_file_addr(o_register_file_addr),
    .o_register_file_ce(o_register_file_ce), .o_data_memory_addr(o_data_memory_addr),
    .o_memory_write_enable(o_memory_write_enable), .o_memory_read_enable(o_memory_read_enable),
    .o_acumulator_ce(o_acumulator_ce), .o_direct_data(o_direct_data), .o_direct_load(o_direct_load)
  );

  always #5 i_clk = ~i_clk;

  assign act = {o_operation_code, o_register_file_addr, o_register_file_ce, o_data_memory_addr,
                o_memory_write_enable, o_memory_read_enable, o_acumulator_ce, o_direct_data, o_direct_load};

  function automatic logic [29:0] model(logic [15:0] ins);
    logic [3:0] o;
    logic [2:0] alu, rf;
    logic wr, rd, acc, dl;
    o = ins[5:2];
    alu = (o >= 1 && o <= 5) ? o[2:0] : o == 6 ? 3'd1 : o == 7 ? 3'd2 : o == 14 ? 3'd6 : o == 15 ? 3'd7 : 3'd0;
    rf = {o == 4'd13, o == 4'd11, (o >= 1 && o <= 5) || o == 4'd8};
    wr = o == 4'd12;
    rd = o inside {4'd6, 4'd7, 4'd9, 4'd13};
    acc = (o >= 1 && o <= 10) || o >= 14;
    dl = o == 4'd10;
    return {alu, ins[1:0], rf, ins[15:6], wr, rd, acc, ins[13:6], dl};
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  always @(posedge i_clk) begin
    exp_q = i_rst ? 30'd0 : model(i_instruction);
    exp_valid = 1'b1;
  end

  always @(negedge i_clk) if (exp_valid) chk("decode_model", {2'b0, act}, {2'b0, exp_q});

  task automatic apply(logic r, logic [15:0] ins);
    @(negedge i_clk);
    i_rst = r;
    i_instruction = ins;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [29:0] hold;
    apply(1'b1, 16'hFFFF);
    apply(1'b1, 16'hFFFF);
    chk("reset_all_zero", {2'b0, act}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, {10'h155, 4'(k), 2'b11});
      chk("sweep_rf_addr", {30'd0, o_register_file_addr}, 32'd3);
      if (k == 1) begin
        chk("add_r_op", {29'd0, o_operation_code}, 32'd1);
        chk("add_r_rfce", {29'd0, o_register_file_ce}, 32'd1);
        chk("add_r_acc", {31'd0, o_acumulator_ce}, 32'd1);
      end
      if (k == 13) chk("ld_rm_rfce_rd", {28'd0, o_register_file_ce, o_memory_read_enable}, 32'h9);
      if (k == 15) chk("clr_a_op", {29'd0, o_operation_code}, 32'd7);
    end
    apply(1'b0, {10'h155, 4'd0, 2'b11});
    chk("wrap_nop", {2'b0, act}, {2'b0, 3'd0, 2'd3, 3'd0, 10'h155, 3'd0, 8'h55, 1'b0});
    apply(1'b0, {10'h2A5, 4'(LD_AI), 2'b01});
    chk("fld_mem_addr", {22'd0, o_data_memory_addr}, 32'h2A5);
    chk("fld_direct_data", {24'd0, o_direct_data}, 32'hA5);
    chk("fld_dl_acc", {30'd0, o_direct_load, o_acumulator_ce}, 32'h3);
    chk("fld_rf_addr", {30'd0, o_register_file_addr}, 32'd1);
    apply(1'b0, {10'h3FF, 4'(ST_MA), 2'b00});
    chk("st_ma_wr_rd", {30'd0, o_memory_write_enable, o_memory_read_enable}, 32'h2);
    chk("st_ma_addr", {22'd0, o_data_memory_addr}, 32'h3FF);
    apply(1'b0, {10'h3FF, 4'(LD_AM), 2'b00});
    chk("ld_am_wr_rd_acc", {29'd0, o_memory_write_enable, o_memory_read_enable, o_acumulator_ce}, 32'h3);
    for (int k = 0; k < 40; k++) begin
      apply(1'b0, 16'($urandom));
      hold = act;
      #3;
      chk("stable_between_edges", {2'b0, act}, {2'b0, hold});
      chk("inv_mem_excl", {31'd0, o_memory_write_enable & o_memory_read_enable}, 32'd0);
      chk("inv_dl_acc", {31'd0, o_direct_load & ~o_acumulator_ce}, 32'd0);
    end
    apply(1'b1, {10'h0F0, 4'(ADD_R), 2'b10});
    chk("midreset_zero", {2'b0, act}, 32'd0);
    apply(1'b0, {10'h0F0, 4'(LD_RM), 2'b10});
    chk("after_reset_ld_rm", {2'b0, act}, {2'b0, 3'd0, 2'd2, 3'b100, 10'h0F0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0});
    @(negedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
